serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that computes `a_i - b_i - brw_i` on WIDTH-bit operands with a single one-bit full subtractor cell (`full_sub_with_halfsub`), issuing one bit per clock, LSB first. It accepts operands through a valid/ready handshake, sequences WIDTH subtract steps while carrying the borrow between steps, and presents the difference, final borrow and a zero flag through a second valid/ready handshake. It trades area for latency wherever the datapath needs wide subtraction without a ripple chain.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range is 1 to 64.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  operands valid.
- `in_ready_o`  out  1  block can accept operands; high only in IDLE.
- `a_i`  in  WIDTH  minuend.
- `b_i`  in  WIDTH  subtrahend.
- `brw_i`  in  1  borrow-in applied at bit 0.
- `out_valid_o`  out  1  result valid; high only in DONE.
- `out_ready_i`  in  1  consumer accepts result.
- `dif_o`  out  WIDTH  difference, `(a - b - brw) mod 2^WIDTH`.
- `brw_o`  out  1  final borrow; 1 when `a < b + brw` (unsigned).
- `zero_o`  out  1  1 when `dif_o == 0`.
- `busy_o`  out  1  high in RUN.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are either registered or decoded from the state.
- **IDLE**
  - `in_ready_o` = 1.
  - An edge with `in_valid_i` high loads `a_i` and `b_i` into shift registers and `brw_i` into the borrow register, clears the bit counter, and moves the FSM to RUN.
  - Operands are sampled only on the accepting edge.
- **RUN**
  - Each edge feeds `a_sr[0]`, `b_sr[0]` and the borrow register into the full subtractor cell.
  - The cell's difference bit shifts into the MSB of the result shift register (shift right). The cell's borrow-out replaces the borrow register. `a_sr` and `b_sr` shift right. The counter increments.
  - On the edge that processes bit WIDTH-1:
    - the complete result loads into the `dif_o` register;
    - the final borrow loads into `brw_o`;
    - `zero_o` is set to `(result == 0)`;
    - the FSM moves to DONE.
  - `in_valid_i` is ignored.
- **DONE**
  - `out_valid_o` = 1. `dif_o`, `brw_o` and `zero_o` are held stable.
  - An edge with `out_ready_i` high moves the FSM to IDLE.
  - `in_ready_o` = 0, so a new operation cannot be accepted in the same cycle as the output handshake.
- `dif_o`, `brw_o` and `zero_o` change only on the final RUN edge or on reset. They keep their last value through IDLE and the next RUN.
- The bit counter is `$clog2(WIDTH+1)` bits wide and never wraps: RUN exits at count WIDTH-1.
- With WIDTH=1, RUN lasts exactly one edge.
- Reset:
  - A reset edge forces IDLE and clears all shift, borrow, counter and output registers, regardless of state (including mid-RUN and DONE).
  - Reset dominates `in_valid_i` and `out_ready_i` on the same edge.
  - After a reset edge: `in_ready_o`=1, `out_valid_o`=0, `busy_o`=0, `dif_o`=0, `brw_o`=0, `zero_o`=0.

## Timing
- The operand-accepting edge is E0.
- Bit k is processed on edge E(k+1).
- `out_valid_o` rises after edge E(WIDTH), so latency is WIDTH cycles.
- If `out_ready_i` is already high, DONE lasts one cycle. IDLE is reached after E(WIDTH+1), and the next operands are accepted at E(WIDTH+2), so minimum spacing between accepts is WIDTH+2 cycles.
- Backpressure: DONE holds indefinitely while `out_ready_i` is low. No input is accepted during that time.
- There is no combinational path from `in_valid_i` or `out_ready_i` to any output.

## Test plan
- Basic subtract, WIDTH=8: `a`=0x5A, `b`=0x3C, `brw`=0 → after 8 cycles `dif_o`=0x1E, `brw_o`=0, `zero_o`=0; `busy_o` high for exactly 8 cycles.
- Underflow: `a`=0x00, `b`=0x01, `brw`=0 → `dif_o`=0xFF, `brw_o`=1. `a`=0x10, `b`=0x10, `brw`=1 → `dif_o`=0xFF, `brw_o`=1. `a`=0x10, `b`=0x10, `brw`=0 → `dif_o`=0x00, `brw_o`=0, `zero_o`=1.
- Backpressure: hold `out_ready_i`=0 for 5 cycles in DONE while driving `in_valid_i`=1 with new operands → outputs stay stable, `in_ready_o`=0, and no new operation starts. Then raise `out_ready_i` → IDLE next cycle, and the new operands are accepted one cycle later.
- Back-to-back with `out_ready_i` tied high and `in_valid_i` held high → accepts occur every 10 cycles (WIDTH+2); results match a reference model over 1000 random operand sets.
- Reset mid-RUN: assert `rst_i` on the 3rd RUN edge → next cycle in IDLE with `busy_o`=0, `out_valid_o`=0, `dif_o`=0, `brw_o`=0, `in_ready_o`=1. A subsequent operation `a`=0x05, `b`=0x03 completes with `dif_o`=0x02.
- WIDTH=1: `a`=0, `b`=1, `brw`=1 → after 1 cycle `dif_o`=0, `brw_o`=1, `zero_o`=1.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if
// Bundles the operand and result handshakes of serial_sub_ctrl.
//   in_valid_i / in_ready_o   : operand handshake (a_i, b_i, brw_i)
//   out_valid_o / out_ready_i : result handshake (dif_o, brw_o, zero_o)
//   busy_o                    : subtraction in progress
// The slave modport is the controller's view; master is the driver/consumer view.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             brw_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] dif_o;
    logic             brw_o;
    logic             zero_o;
    logic             busy_o;

    modport slave (
        input  in_valid_i, a_i, b_i, brw_i, out_ready_i,
        output in_ready_o, out_valid_o, dif_o, brw_o, zero_o, busy_o
    );

    modport master (
        output in_valid_i, a_i, b_i, brw_i, out_ready_i,
        input  in_ready_o, out_valid_o, dif_o, brw_o, zero_o, busy_o
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial a - b - brw over WIDTH bits, one bit per clock, LSB first, using
// a single full subtractor cell built from two half subtractors.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : serial_sub_ctrl_if.slave (operand/result handshakes, busy)
//
// state | meaning
// IDLE  | in_ready_o=1, waiting for operands
// RUN   | one subtract step per edge, WIDTH edges total
// DONE  | out_valid_o=1, result held until out_ready_i

module full_sub_with_halfsub (
    input  logic a_i,
    input  logic b_i,
    input  logic brw_i,
    output logic dif_o,
    output logic brw_o
);
    logic d1;
    logic b1;
    logic b2;

    assign d1    = a_i ^ b_i;
    assign b1    = ~a_i & b_i;
    assign dif_o = d1 ^ brw_i;
    assign b2    = ~d1 & brw_i;
    assign brw_o = b1 | b2;
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dif_q;
    logic             brw_out_q;
    logic             zero_q;

    logic             cell_dif;
    logic             cell_brw;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    full_sub_with_halfsub u_cell (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .brw_i (brw_q),
        .dif_o (cell_dif),
        .brw_o (cell_brw)
    );

    // Difference bits enter at the MSB so after WIDTH steps bit 0 sits at LSB.
    always_comb begin
        res_next            = res_sr_q >> 1;
        res_next[WIDTH-1]   = cell_dif;
    end

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid_i)  state_d = RUN;
            RUN:     if (last_bit)        state_d = DONE;
            DONE:    if (bus.out_ready_i) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = (state_q == IDLE);
        bus.busy_o      = (state_q == RUN);
        bus.out_valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            res_sr_q  <= '0;
            brw_q     <= 1'b0;
            cnt_q     <= '0;
            dif_q     <= '0;
            brw_out_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_sr_q <= bus.a_i;
                        b_sr_q <= bus.b_i;
                        brw_q  <= bus.brw_i;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_next;
                    brw_q    <= cell_brw;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        dif_q     <= res_next;
                        brw_out_q <= cell_brw;
                        zero_q    <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dif_o  = dif_q;
    assign bus.brw_o  = brw_out_q;
    assign bus.zero_o = zero_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8.slave));
    serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, difference} of a - b - c as plain wide arithmetic.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return {1'b0, a} - {1'b0, b} - 9'(c);
    endfunction

    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        return {1'b0, a} - {1'b0, b} - 2'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits from just after the accept edge until out_valid; returns edges taken and busy samples.
    task automatic wait_done8(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!bus8.out_valid_o && n < 100) begin
            if (bus8.busy_o) busy_cnt++;
            tick();
            n++;
        end
        check("done_timeout", 64'(bus8.out_valid_o), 64'd1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic check_zero, input logic zexp);
        logic [8:0] r;
        int n, bc;
        r = ref8(a, b, c);
        bus8.a_i = a; bus8.b_i = b; bus8.brw_i = c; bus8.in_valid_i = 1'b1;
        tick();
        bus8.in_valid_i = 1'b0;
        check({tag, "_inready_run"}, 64'(bus8.in_ready_o), 64'd0);
        wait_done8(n, bc);
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_busycycles"}, 64'(bc), 64'd8);
        check({tag, "_dif"}, 64'(bus8.dif_o), 64'(r[7:0]));
        check({tag, "_brw"}, 64'(bus8.brw_o), 64'(r[8]));
        if (check_zero) check({tag, "_zero"}, 64'(bus8.zero_o), 64'(zexp));
        bus8.out_ready_i = 1'b1;
        tick();
        bus8.out_ready_i = 1'b0;
        check({tag, "_idle"}, 64'(bus8.in_ready_o), 64'd1);
    endtask

    initial begin
        logic [7:0] sdif;
        logic [8:0] r;
        logic [1:0] r1;
        logic [7:0] ra, rb;
        logic rc;
        int n, bc, acc, prev;

        bus8.in_valid_i = 0; bus8.a_i = 0; bus8.b_i = 0; bus8.brw_i = 0; bus8.out_ready_i = 0;
        bus1.in_valid_i = 0; bus1.a_i = 0; bus1.b_i = 0; bus1.brw_i = 0; bus1.out_ready_i = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        check("rst_inready", 64'(bus8.in_ready_o), 64'd1);
        check("rst_outvalid", 64'(bus8.out_valid_o), 64'd0);
        check("rst_busy", 64'(bus8.busy_o), 64'd0);
        check("rst_dif", 64'(bus8.dif_o), 64'd0);
        check("rst_brw", 64'(bus8.brw_o), 64'd0);
        check("rst_zero", 64'(bus8.zero_o), 64'd0);

        op8("basic", 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);
        check("basic_const", 64'(bus8.dif_o), 64'h1E);
        op8("uflow1", 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
        check("uflow1_const", 64'(bus8.dif_o), 64'hFF);
        op8("uflow2", 8'h10, 8'h10, 1'b1, 1'b1, 1'b0);
        check("uflow2_brw_const", 64'(bus8.brw_o), 64'd1);
        op8("equal", 8'h10, 8'h10, 1'b0, 1'b1, 1'b1);
        op8("basic2", 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);

        // Reset on the third RUN edge.
        bus8.a_i = 8'h77; bus8.b_i = 8'h11; bus8.brw_i = 0; bus8.in_valid_i = 1;
        tick();
        bus8.in_valid_i = 0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(bus8.busy_o), 64'd0);
        check("midrst_outvalid", 64'(bus8.out_valid_o), 64'd0);
        check("midrst_dif", 64'(bus8.dif_o), 64'd0);
        check("midrst_brw", 64'(bus8.brw_o), 64'd0);
        check("midrst_inready", 64'(bus8.in_ready_o), 64'd1);
        op8("postrst", 8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
        check("postrst_const", 64'(bus8.dif_o), 64'h02);

        // Backpressure with new operands pending.
        bus8.a_i = 8'hC3; bus8.b_i = 8'h5E; bus8.brw_i = 1; bus8.in_valid_i = 1;
        tick();
        bus8.a_i = 8'h33; bus8.b_i = 8'h11; bus8.brw_i = 0;
        wait_done8(n, bc);
        r = ref8(8'hC3, 8'h5E, 1'b1);
        check("bp_dif", 64'(bus8.dif_o), 64'(r[7:0]));
        sdif = bus8.dif_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_outvalid", 64'(bus8.out_valid_o), 64'd1);
            check("bp_inready", 64'(bus8.in_ready_o), 64'd0);
            check("bp_busy", 64'(bus8.busy_o), 64'd0);
            check("bp_stable", 64'(bus8.dif_o), 64'(sdif));
            check("bp_brw_stable", 64'(bus8.brw_o), 64'(r[8]));
        end
        bus8.out_ready_i = 1;
        tick();
        bus8.out_ready_i = 0;
        check("bp_release_idle", 64'(bus8.in_ready_o), 64'd1);
        check("bp_release_outvalid", 64'(bus8.out_valid_o), 64'd0);
        tick();
        bus8.in_valid_i = 0;
        check("bp_accept_next", 64'(bus8.busy_o), 64'd1);
        wait_done8(n, bc);
        check("bp_next_dif", 64'(bus8.dif_o), 64'h22);
        bus8.out_ready_i = 1;
        tick();

        // Back-to-back random operations, in_valid and out_ready held high.
        bus8.in_valid_i = 1;
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            bus8.a_i = ra; bus8.b_i = rb; bus8.brw_i = rc;
            tick();
            check("b2b_accept", 64'(bus8.busy_o), 64'd1);
            acc = cyc;
            if (i > 0) check("b2b_spacing", 64'(acc - prev), 64'd10);
            prev = acc;
            bus8.a_i = ~ra; bus8.b_i = ~rb; bus8.brw_i = ~rc;
            wait_done8(n, bc);
            r = ref8(ra, rb, rc);
            check("b2b_dif", 64'(bus8.dif_o), 64'(r[7:0]));
            check("b2b_brw", 64'(bus8.brw_o), 64'(r[8]));
            check("b2b_zero", 64'(bus8.zero_o), 64'(r[7:0] == 8'd0));
            if (i == 999) bus8.in_valid_i = 0;
            tick();
        end
        bus8.out_ready_i = 0;

        // WIDTH=1 instance: directed case then all operand combinations.
        for (int k = -1; k < 8; k++) begin
            logic a1, b1, c1;
            if (k < 0) begin a1 = 0; b1 = 1; c1 = 1; end
            else begin a1 = k[0]; b1 = k[1]; c1 = k[2]; end
            r1 = ref1(a1, b1, c1);
            bus1.a_i = a1; bus1.b_i = b1; bus1.brw_i = c1; bus1.in_valid_i = 1;
            tick();
            bus1.in_valid_i = 0;
            check("w1_busy", 64'(bus1.busy_o), 64'd1);
            tick();
            check("w1_outvalid", 64'(bus1.out_valid_o), 64'd1);
            check("w1_dif", 64'(bus1.dif_o), 64'(r1[0]));
            check("w1_brw", 64'(bus1.brw_o), 64'(r1[1]));
            check("w1_zero", 64'(bus1.zero_o), 64'(r1[0] == 1'b0));
            bus1.out_ready_i = 1;
            tick();
            bus1.out_ready_i = 0;
            check("w1_idle", 64'(bus1.in_ready_o), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
